// File: rtl/builtin_sched.sv
// builtin_sched: round-robin scheduler that shares one builtin unit (SEXT2/ZEXT/CLOG2/POW2)
// among N_REQ requesters, with one operation in flight and a one-cycle result strobe.
module builtin_sched #(
  parameter int N_REQ = 4,
  parameter int WIDTH = 8
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [N_REQ-1:0]       req_valid,
  input  logic [2*N_REQ-1:0]     req_op,
  input  logic [WIDTH*N_REQ-1:0] req_data,
  output logic [N_REQ-1:0]       req_ready,
  output logic                   resp_valid,
  output logic [1:0]             resp_id,
  output logic [WIDTH-1:0]       resp_data,
  output logic [15:0]            op_count
);
  localparam int IDW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CW  = $clog2(WIDTH) + 1;

  localparam logic [1:0] OP_SEXT2 = 2'd0;
  localparam logic [1:0] OP_ZEXT  = 2'd1;
  localparam logic [1:0] OP_CLOG2 = 2'd2;
  localparam logic [1:0] OP_POW2  = 2'd3;

  typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, DONE = 2'd2} state_t;

  state_t           state_r, state_s;
  logic [1:0]       op_a_s   [N_REQ];
  logic [WIDTH-1:0] data_a_s [N_REQ];
  logic [IDW-1:0]   gidx_s, prio_r, id_r;
  logic [IDW:0]     sum_s;
  logic             found_s, accept_s, exec_last_s;
  logic [1:0]       op_r;
  logic [WIDTH-1:0] data_r;
  logic [WIDTH:0]   m_r, acc_r, result_s;
  logic [CW-1:0]    cnt_r;
  logic             resp_valid_r;
  logic [1:0]       resp_id_r;
  logic [WIDTH-1:0] resp_data_r;
  logic [15:0]      op_count_r;

  // Single-cycle ops; POW2 lands in bit WIDTH when src == WIDTH and is zeroed on output.
  function automatic logic [WIDTH:0] fn_single(input logic [1:0] op, input logic [WIDTH-1:0] src);
    logic [WIDTH:0] res;
    case (op)
      OP_SEXT2: res = {1'b0, {(WIDTH-2){src[1]}}, src[1:0]};
      OP_ZEXT:  res = {1'b0, src};
      OP_POW2:  res = (WIDTH+1)'(1) << src;
      default:  res = '0;
    endcase
    return res;
  endfunction

  // ceil(log2(src)) is the bit length of src-1; src of 0 or 1 seeds zero.
  function automatic logic [WIDTH:0] fn_clog2_seed(input logic [WIDTH-1:0] src);
    logic [WIDTH:0] seed;
    if (src <= WIDTH'(1)) begin
      seed = '0;
    end else begin
      seed = {1'b0, src} - (WIDTH+1)'(1);
    end
    return seed;
  endfunction

  // Unpack per-requester opcode and operand slices.
  always_comb begin
    for (int i = 0; i < N_REQ; i++) begin
      op_a_s[i]   = req_op[2*i +: 2];
      data_a_s[i] = req_data[WIDTH*i +: WIDTH];
    end
  end

  // Round-robin search starting at the priority pointer.
  always_comb begin
    found_s = 1'b0;
    gidx_s  = '0;
    sum_s   = '0;
    for (int i = 0; i < N_REQ; i++) begin
      sum_s = {1'b0, prio_r} + (IDW+1)'(i);
      if (sum_s >= (IDW+1)'(N_REQ)) begin
        sum_s = sum_s - (IDW+1)'(N_REQ);
      end else begin
        sum_s = sum_s;
      end
      if (!found_s && req_valid[sum_s[IDW-1:0]]) begin
        found_s = 1'b1;
        gidx_s  = sum_s[IDW-1:0];
      end else begin
        found_s = found_s;
      end
    end
  end

  assign accept_s    = (state_r == IDLE) && found_s;
  assign exec_last_s = (op_r != OP_CLOG2) || (cnt_r == CW'(WIDTH-1));

  // Result of the final EXEC cycle; CLOG2 folds in the last bit examined.
  always_comb begin
    if (op_r == OP_CLOG2) begin
      if (m_r[0]) begin
        result_s = (WIDTH+1)'(cnt_r) + (WIDTH+1)'(1);
      end else begin
        result_s = acc_r;
      end
    end else begin
      result_s = fn_single(op_r, data_r);
    end
  end

  // State register.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic.
  always_comb begin
    case (state_r)
      IDLE:    state_s = accept_s ? EXEC : IDLE;
      EXEC:    state_s = exec_last_s ? DONE : EXEC;
      DONE:    state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // Grant output: combinational in IDLE only.
  always_comb begin
    if (accept_s) begin
      req_ready = N_REQ'(1) << gidx_s;
    end else begin
      req_ready = '0;
    end
  end

  // Operand capture, priority pointer and iterative CLOG2 scan.
  always_ff @(posedge clock) begin
    if (reset) begin
      op_r   <= 2'd0;
      data_r <= '0;
      id_r   <= '0;
      m_r    <= '0;
      acc_r  <= '0;
      cnt_r  <= '0;
      prio_r <= '0;
    end else if (accept_s) begin
      op_r   <= op_a_s[gidx_s];
      data_r <= data_a_s[gidx_s];
      id_r   <= gidx_s;
      m_r    <= fn_clog2_seed(data_a_s[gidx_s]);
      acc_r  <= '0;
      cnt_r  <= '0;
      prio_r <= (gidx_s == IDW'(N_REQ-1)) ? '0 : gidx_s + IDW'(1);
    end else if (state_r == EXEC && op_r == OP_CLOG2) begin
      m_r   <= m_r >> 1;
      cnt_r <= cnt_r + CW'(1);
      if (m_r[0]) begin
        acc_r <= (WIDTH+1)'(cnt_r) + (WIDTH+1)'(1);
      end
    end
  end

  // Response registers: loaded on the edge into DONE, cleared otherwise.
  always_ff @(posedge clock) begin
    if (reset) begin
      resp_valid_r <= 1'b0;
      resp_id_r    <= 2'd0;
      resp_data_r  <= '0;
    end else if (state_r == EXEC && exec_last_s) begin
      resp_valid_r <= 1'b1;
      resp_id_r    <= 2'(id_r);
      resp_data_r  <= result_s[WIDTH] ? '0 : result_s[WIDTH-1:0];
    end else begin
      resp_valid_r <= 1'b0;
      resp_id_r    <= 2'd0;
      resp_data_r  <= '0;
    end
  end

  // Completed-operation counter, wraps naturally.
  always_ff @(posedge clock) begin
    if (reset) begin
      op_count_r <= 16'd0;
    end else if (state_r == DONE) begin
      op_count_r <= op_count_r + 16'd1;
    end
  end

  assign resp_valid = resp_valid_r;
  assign resp_id    = resp_id_r;
  assign resp_data  = resp_data_r;
  assign op_count   = op_count_r;
endmodule

// File: tb/tb_builtin_sched.sv
// Directed bench for builtin_sched: ops, latency, round-robin order, reset abort, counter wrap.
module tb_builtin_sched;
  localparam int N_REQ = 4;
  localparam int WIDTH = 8;
  localparam logic [1:0] SEXT2 = 2'd0, ZEXT = 2'd1, CLOG2 = 2'd2, POW2 = 2'd3;

  logic                   clock = 1'b0;
  logic                   reset;
  logic [N_REQ-1:0]       req_valid;
  logic [2*N_REQ-1:0]     req_op;
  logic [WIDTH*N_REQ-1:0] req_data;
  logic [N_REQ-1:0]       req_ready;
  logic                   resp_valid;
  logic [1:0]             resp_id;
  logic [WIDTH-1:0]       resp_data;
  logic [15:0]            op_count;

  int          n_checks = 0;
  int          n_pass   = 0;
  logic [15:0] exp_count = 16'd0;
  int          strobes;
  int          k;

  builtin_sched #(.N_REQ(N_REQ), .WIDTH(WIDTH)) dut (
    .clock(clock), .reset(reset), .req_valid(req_valid), .req_op(req_op),
    .req_data(req_data), .req_ready(req_ready), .resp_valid(resp_valid),
    .resp_id(resp_id), .resp_data(resp_data), .op_count(op_count)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    exp_count = 16'd0;
  endtask

  // Issue one request from an idle negedge; returns at the negedge after DONE.
  task automatic do_op(input string tag, input int id, input logic [1:0] op,
                       input logic [7:0] src, input logic [7:0] exp_d, input int exp_lat);
    int lat;
    req_valid = 4'b0001 << id;
    req_op[2*id +: 2] = op;
    req_data[8*id +: 8] = src;
    #1;
    check({tag, "_ready"}, req_ready, 4'b0001 << id);
    @(posedge clock);
    #1;
    req_valid = '0;
    req_op    = '1;
    req_data  = '1;
    lat = 0;
    for (int j = 1; j <= 24; j++) begin
      @(negedge clock);
      if (resp_valid) begin
        lat = j;
        break;
      end
    end
    check({tag, "_lat"}, lat, exp_lat);
    check({tag, "_id"}, resp_id, id);
    check({tag, "_data"}, resp_data, exp_d);
    exp_count = exp_count + 16'd1;
    @(negedge clock);
    check({tag, "_idle"}, {resp_valid, resp_id, resp_data}, 0);
    check({tag, "_cnt"}, op_count, exp_count);
  endtask

  initial begin
    reset = 1'b1;
    req_valid = '0;
    req_op = '0;
    req_data = '0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    check("rst_ready", req_ready, 0);
    check("rst_resp", {resp_valid, resp_id, resp_data}, 0);
    check("rst_cnt", op_count, 0);
    reset = 1'b0;

    do_op("sext2_2", 1, SEXT2, 8'h02, 8'hFE, 2);
    do_op("sext2_1", 1, SEXT2, 8'h01, 8'h01, 2);
    do_op("sext2_3", 2, SEXT2, 8'hF3, 8'hFF, 2);
    do_op("zext", 0, ZEXT, 8'd100, 8'h64, 2);
    do_op("pow2_4", 0, POW2, 8'd4, 8'h10, 2);
    do_op("pow2_7", 0, POW2, 8'd7, 8'h80, 2);
    do_op("pow2_8", 0, POW2, 8'd8, 8'h00, 2);
    do_op("pow2_9", 0, POW2, 8'd9, 8'h00, 2);
    do_op("clog_100", 0, CLOG2, 8'd100, 8'd7, 9);
    do_op("clog_1", 3, CLOG2, 8'd1, 8'd0, 9);
    do_op("clog_0", 0, CLOG2, 8'd0, 8'd0, 9);
    do_op("clog_2", 0, CLOG2, 8'd2, 8'd1, 9);
    do_op("clog_128", 0, CLOG2, 8'd128, 8'd7, 9);
    do_op("clog_129", 0, CLOG2, 8'd129, 8'd8, 9);
    do_op("clog_255", 0, CLOG2, 8'd255, 8'd8, 9);

    // All four requesters pending: grants rotate 0,1,2,3,0.
    apply_reset();
    req_op    = {ZEXT, ZEXT, ZEXT, ZEXT};
    req_data  = {8'h40, 8'h30, 8'h20, 8'h10};
    req_valid = 4'b1111;
    for (int g = 0; g < 5; g++) begin
      #1;
      check("rr_grant", req_ready, 4'b0001 << (g % 4));
      k = 0;
      do begin
        @(negedge clock);
        k++;
      end while (!resp_valid && k < 20);
      check("rr_id", resp_id, g % 4);
      check("rr_data", resp_data, 8'h10 * ((g % 4) + 1));
      check("rr_ready_done", req_ready, 0);
      @(negedge clock);
    end
    check("rr_cnt", op_count, 5);
    req_valid = '0;

    // Reset in the 4th EXEC cycle of a CLOG2 from requester 2.
    apply_reset();
    req_op[5:4]     = CLOG2;
    req_data[23:16] = 8'd100;
    req_valid       = 4'b0100;
    @(posedge clock);
    #1;
    req_valid = '0;
    strobes = 0;
    for (int j = 0; j < 4; j++) begin
      @(negedge clock);
      strobes += int'(resp_valid);
    end
    reset = 1'b1;
    @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    for (int j = 0; j < 12; j++) begin
      @(negedge clock);
      strobes += int'(resp_valid);
    end
    check("abort_strobes", strobes, 0);
    check("abort_cnt", op_count, 0);
    req_op = {ZEXT, ZEXT, ZEXT, ZEXT};
    req_data = {8'h44, 8'h33, 8'h22, 8'h11};
    req_valid = 4'b1001;
    #1;
    check("abort_grant", req_ready, 4'b0001);
    @(posedge clock);
    #1;
    req_valid = '0;
    k = 0;
    do begin
      @(negedge clock);
      k++;
    end while (!resp_valid && k < 20);
    check("abort_next_id", resp_id, 0);
    check("abort_next_data", resp_data, 8'h11);
    @(negedge clock);

    // Reset wins over an acceptance on the same edge.
    reset = 1'b1;
    req_valid = 4'b0001;
    @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    req_valid = '0;
    strobes = 0;
    for (int j = 0; j < 5; j++) begin
      @(negedge clock);
      strobes += int'(resp_valid);
    end
    check("rst_accept_strobes", strobes, 0);
    check("rst_accept_cnt", op_count, 0);

    // Withdrawn request leaves no trace.
    req_valid = 4'b0010;
    #1;
    check("wd_ready", req_ready, 4'b0010);
    #2;
    req_valid = '0;
    strobes = 0;
    for (int j = 0; j < 6; j++) begin
      @(negedge clock);
      strobes += int'(resp_valid);
    end
    check("wd_strobes", strobes, 0);
    check("wd_cnt", op_count, 0);

    // Counter wrap.
    force dut.op_count_r = 16'hFFFE;
    @(negedge clock);
    release dut.op_count_r;
    @(negedge clock);
    check("wrap_preset", op_count, 16'hFFFE);
    exp_count = 16'hFFFE;
    do_op("wrap_a", 2, ZEXT, 8'h5A, 8'h5A, 2);
    do_op("wrap_b", 3, POW2, 8'd0, 8'h01, 2);
    check("wrap_zero", op_count, 16'h0000);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
